// File: rtl/ebus_pkg.sv
// ebus_pkg: shared types and helpers for the ebus responder
package ebus_pkg;
    typedef logic [35:0] word_t;
    typedef enum logic [2:0] {CONO = 3'd0, CONI = 3'd1, DATAO = 3'd2, DATAI = 3'd3} func_e;
    typedef enum logic [2:0] {IDLE, DECODE, DELAY, XFER, IGNORE} state_e;
    function automatic logic is_supported(logic [2:0] f);
        return !f[2];
    endfunction
    function automatic logic is_read(logic [2:0] f);
        return f == CONI || f == DATAI;
    endfunction
endpackage

// File: rtl/ebus_responder_if.sv
// ebus_responder_if: initiator/responder handshake and data signals
interface ebus_responder_if;
    import ebus_pkg::*;
    logic ebusDemand;
    logic [6:0] ebusCS;
    logic [2:0] ebusFunc;
    word_t ebusDataIn;
    logic ebusXfer;
    word_t ebusDataOut;
    logic ebusDataOE;
    modport master(output ebusDemand, ebusCS, ebusFunc, ebusDataIn, input ebusXfer, ebusDataOut, ebusDataOE);
    modport slave(input ebusDemand, ebusCS, ebusFunc, ebusDataIn, output ebusXfer, ebusDataOut, ebusDataOE);
endinterface

// File: rtl/ebus_delay_ctr.sv
// ebus_delay_ctr: loadable down-counter; zero rises the cycle after the count reaches 0
module ebus_delay_ctr (
    input  logic       clk,
    input  logic       resetN,
    input  logic       load,
    input  logic [3:0] val,
    output logic       zero
);
    logic [3:0] cnt;
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            cnt <= '0;
            zero <= 1'b0;
        end else if (load) begin
            cnt <= val;
            zero <= 1'b0;
        end else begin
            cnt <= cnt - 4'(cnt != 4'd0);
            zero <= cnt == 4'd0;
        end
endmodule

// File: rtl/ebus_responder.sv
// ebus_responder: ebus target answering CONO/CONI/DATAO/DATAI with a fixed acknowledge delay
module ebus_responder import ebus_pkg::*; #(
    parameter logic [6:0] MY_CS = 7'o14,
    parameter int XFER_DELAY = 3
) (
    input  logic clk,
    input  logic resetN,
    ebus_responder_if.slave bus,
    output word_t conoReg,
    output word_t dataoReg,
    input  word_t coniIn,
    input  word_t dataiIn
);
    state_e state, nxt;
    logic [2:0] func_q;
    word_t data_q, dout_d;
    logic zero, load, wr, rd;

    ebus_delay_ctr u_ctr (.clk(clk), .resetN(resetN), .load(load), .val(4'(XFER_DELAY - 1)), .zero(zero));

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            state <= IDLE;
            func_q <= '0;
            data_q <= '0;
            bus.ebusXfer <= 1'b0;
            bus.ebusDataOE <= 1'b0;
            bus.ebusDataOut <= '0;
            conoReg <= '0;
            dataoReg <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE) begin
                func_q <= bus.ebusFunc;
                data_q <= bus.ebusDataIn;
            end
            bus.ebusXfer <= nxt == XFER;
            bus.ebusDataOE <= rd;
            bus.ebusDataOut <= dout_d;
            if (wr && func_q == CONO) conoReg <= data_q;
            if (wr && func_q == DATAO) dataoReg <= data_q;
        end

    // Only transitions on a sampled-low demand lead back to IDLE, so held demand can't retrigger
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:        nxt = !bus.ebusDemand ? IDLE : (bus.ebusCS == MY_CS ? DECODE : IGNORE);
            DECODE:      nxt = !bus.ebusDemand ? IDLE : (is_supported(bus.ebusFunc) ? DELAY : IGNORE);
            DELAY:       nxt = !bus.ebusDemand ? IDLE : (zero ? XFER : DELAY);
            XFER:        nxt = bus.ebusDemand ? XFER : IDLE;
            IGNORE:      nxt = bus.ebusDemand ? IGNORE : IDLE;
            default:     nxt = IDLE;
        endcase
    end

    always_comb begin
        load = state == DECODE;
        wr = state == DELAY && nxt == XFER;
        rd = nxt == XFER && is_read(func_q);
        dout_d = !rd ? '0 : (func_q == CONI ? coniIn : dataiIn);
    end
endmodule
